mux_n_pipe: RTL and testbench
=============================

Name: mux_n_pipe

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered output stage, for the 5-stage pipeline datapath (forwarding-source and writeback-source selection).
- Replaces a combinational 2-way select plus a separate pipeline register.
- Adds binary or one-hot select mode, stall/flush control, a valid bit, and select-error detection with a saturating error counter.

Parameters:
- WIDTH, 32: data width of each input and of the output.
- N, 4: number of input channels, 2..16.
- SEL_MODE, 0: 0 = binary select on sel_bin, 1 = one-hot select on sel_oh.
- RESET_VAL, 0: value loaded into dout on reset and on flush (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- din  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- sel_bin  input  $clog2(N)  binary channel index; used only when SEL_MODE=0
- sel_oh  input  N  one-hot channel select; used only when SEL_MODE=1
- in_valid  input  1  current input/select is meaningful
- stall  input  1  hold all registered outputs
- flush  input  1  bubble-insert: clear the stage
- dout  output  WIDTH  registered selected data
- out_valid  output  1  dout holds a captured valid sample
- sel_err  output  1  registered: last captured sample had an illegal select
- err_cnt  output  8  saturating count of captured illegal selects

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst). Everything is updated on the rising edge of clk only.
- Reset values: dout=RESET_VAL, out_valid=0, sel_err=0, err_cnt=0.
- Update priority, evaluated each rising edge:
  - rst, then flush, then stall, then load.
  - flush: dout=RESET_VAL, out_valid=0, sel_err=0. err_cnt is held, not cleared.
  - stall (no flush): dout, out_valid, sel_err and err_cnt all hold their values.
  - load (no rst, flush or stall): dout=sel_data, out_valid=in_valid, sel_err=illegal&in_valid.
  - err_cnt increments by 1 when illegal&in_valid, and saturates at 255.
- Latency: exactly 1 cycle from inputs to dout. No combinational path from any input to any output.
- Binary mode (SEL_MODE=0):
  - sel_data = channel sel_bin.
  - If sel_bin >= N (possible only when N is not a power of two): illegal=1, sel_data=0.
- One-hot mode (SEL_MODE=1):
  - Exactly one bit set: sel_data = that channel, illegal=0.
  - sel_oh == 0: illegal=1, sel_data=0.
  - Two or more bits set: illegal=1, sel_data = lowest-index selected channel.
- Data ignores in_valid: when in_valid=0 the selected data is still loaded into dout, but out_valid=0 and no error is recorded.
- Simultaneous flush and stall: flush wins and the stage clears.
- rst asserted mid-stream: all outputs take their reset values on that edge, regardless of stall or flush.
- The unused select port is ignored entirely. No error is ever raised from it.
- Parameter legality, checked at elaboration: N < 2, N > 16, or SEL_MODE not in {0,1} is a fatal elaboration error.

Test Plan:
- Reset: drive N=4, WIDTH=32, rst=1 for 2 cycles with arbitrary din. Required: dout=0x00000000, out_valid=0, sel_err=0, err_cnt=0. On the first edge after rst falls (stall=flush=0, in_valid=1, sel_bin=2, ch2=0xDEADBEEF): dout=0xDEADBEEF, out_valid=1.
- Binary sweep: set chi=0x1000_0000+i and cycle sel_bin through 0,1,2,3 with in_valid=1. Required: dout follows 0x10000000..0x10000003, one cycle late; sel_err stays 0.
- Stall/flush priority:
  - Load 0xAAAA5555, then assert stall for 3 cycles while changing din and sel. Required: dout holds 0xAAAA5555 and out_valid=1.
  - Then assert stall=1 and flush=1 together. Required: dout=RESET_VAL, out_valid=0.
  - Then rst mid-stall. Required: all reset values.
- Binary illegal (N=3): sel_bin=3 with in_valid=1. Required: dout=0, sel_err=1, err_cnt=1. Same with in_valid=0: sel_err=0 and err_cnt unchanged.
- One-hot mode (SEL_MODE=1, N=4, chi=i+1):
  - sel_oh=0100: dout=3, sel_err=0.
  - sel_oh=0110: dout=2, sel_err=1.
  - sel_oh=0000: dout=0, sel_err=1.
  - Final err_cnt=2.
- Counter saturation: 300 consecutive illegal valid loads. Required: err_cnt reaches 255 and holds. A following flush leaves err_cnt=255; only rst returns it to 0.

Source files
------------

// File: rtl/mux_n_pipe_if.sv
// mux_n_pipe_if: select/data bus between a pipeline stage driver and mux_n_pipe
interface mux_n_pipe_if #(parameter int WIDTH = 32, parameter int N = 4);
  logic [N*WIDTH-1:0]   din;
  logic [$clog2(N)-1:0] sel_bin;
  logic [N-1:0]         sel_oh;
  logic                 in_valid;
  logic                 stall;
  logic                 flush;
  logic [WIDTH-1:0]     dout;
  logic                 out_valid;
  logic                 sel_err;
  logic [7:0]           err_cnt;
  modport master(output din, sel_bin, sel_oh, in_valid, stall, flush,
                 input dout, out_valid, sel_err, err_cnt);
  modport slave(input din, sel_bin, sel_oh, in_valid, stall, flush,
                output dout, out_valid, sel_err, err_cnt);
endinterface

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way registered selector with stall/flush, valid and select-error tracking
module mux_n_pipe #(
  parameter int              WIDTH     = 32,
  parameter int              N         = 4,
  parameter int              SEL_MODE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  mux_n_pipe_if.slave bus
);
  if (N < 2 || N > 16 || (SEL_MODE != 0 && SEL_MODE != 1)) begin : g_bad_params
    $fatal(1, "mux_n_pipe: illegal parameters N=%0d SEL_MODE=%0d", N, SEL_MODE);
  end
  logic [N-1:0]     oh_low;
  logic [WIDTH-1:0] sel_data;
  logic             illegal;
  logic             err_load;
  // isolating the lowest set bit gives lowest-index priority on multi-hot selects
  assign oh_low   = bus.sel_oh & (~bus.sel_oh + 1'b1);
  assign err_load = illegal && bus.in_valid;
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++)
      sel_data |= ((SEL_MODE == 1) ? oh_low[i] : (int'(bus.sel_bin) == i)) ? bus.din[i*WIDTH +: WIDTH] : '0;
    illegal = (SEL_MODE == 1) ? (bus.sel_oh == '0 || oh_low != bus.sel_oh) : (int'(bus.sel_bin) >= N);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dout      <= RESET_VAL;
      bus.out_valid <= 1'b0;
      bus.sel_err   <= 1'b0;
      bus.err_cnt   <= 8'd0;
    end else if (bus.flush) begin
      bus.dout      <= RESET_VAL;
      bus.out_valid <= 1'b0;
      bus.sel_err   <= 1'b0;
    end else if (!bus.stall) begin
      bus.dout      <= sel_data;
      bus.out_valid <= bus.in_valid;
      bus.sel_err   <= err_load;
      if (err_load && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: scoreboard bench over three configurations (bin N=4, bin N=3, one-hot N=4)
module tb_mux_n_pipe;
  typedef struct {
    logic [31:0] d;
    logic        v;
    logic        e;
    logic [7:0]  c;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [31:0] md[3];
  logic        mv[3];
  logic        me[3];
  logic [7:0]  mc[3];
  logic [31:0] od[3];
  logic        ov[3];
  logic        oe[3];
  logic [7:0]  oc[3];
  mux_n_pipe_if #(.WIDTH(32), .N(4)) i0 ();
  mux_n_pipe_if #(.WIDTH(32), .N(3)) i1 ();
  mux_n_pipe_if #(.WIDTH(32), .N(4)) i2 ();
  mux_n_pipe #(.WIDTH(32), .N(4), .SEL_MODE(0), .RESET_VAL(32'h0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  mux_n_pipe #(.WIDTH(32), .N(3), .SEL_MODE(0), .RESET_VAL(32'h0)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  mux_n_pipe #(.WIDTH(32), .N(4), .SEL_MODE(1), .RESET_VAL(32'h0)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
  assign od[0] = i0.dout;
  assign od[1] = i1.dout;
  assign od[2] = i2.dout;
  assign ov[0] = i0.out_valid;
  assign ov[1] = i1.out_valid;
  assign ov[2] = i2.out_valid;
  assign oe[0] = i0.sel_err;
  assign oe[1] = i1.sel_err;
  assign oe[2] = i2.sel_err;
  assign oc[0] = i0.err_cnt;
  assign oc[1] = i1.err_cnt;
  assign oc[2] = i2.err_cnt;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, e);
    return {e, c, b, a};
  endfunction
  // reference behaviour: channel choice, then rst > flush > stall > load
  task automatic model(input int k, input logic [127:0] d, input logic [1:0] sb, input logic [3:0] so,
                       input logic v, input logic st, input logic fl, input logic r);
    int n;
    logic ill;
    logic [31:0] sd;
    exp_t e;
    n  = (k == 1) ? 3 : 4;
    sd = '0;
    if (k == 2) begin
      for (int i = 3; i >= 0; i--) if (so[i]) sd = d[i*32 +: 32];
      ill = $countones(so) != 1;
      if (so == 4'b0) sd = '0;
    end else begin
      ill = int'(sb) >= n;
      if (!ill) sd = d[int'(sb)*32 +: 32];
    end
    if (r) begin
      md[k] = '0; mv[k] = 0; me[k] = 0; mc[k] = 0;
    end else if (fl) begin
      md[k] = '0; mv[k] = 0; me[k] = 0;
    end else if (!st) begin
      md[k] = sd; mv[k] = v; me[k] = ill && v;
      if (ill && v && mc[k] != 8'd255) mc[k] = mc[k] + 8'd1;
    end
    e.d = md[k]; e.v = mv[k]; e.e = me[k]; e.c = mc[k];
    q.push_back(e);
  endtask
  // drives channel id with the given stimulus; other instances are held by stall
  task automatic step(input int id, input logic [127:0] d, input logic [1:0] sb, input logic [3:0] so,
                      input logic v, input logic st, input logic fl, input logic r);
    exp_t e;
    rst = r;
    i0.din = d;        i0.sel_bin = sb; i0.sel_oh = so;
    i1.din = d[95:0];  i1.sel_bin = sb; i1.sel_oh = so[2:0];
    i2.din = d;        i2.sel_bin = sb; i2.sel_oh = so;
    i0.in_valid = (id == 0) && v; i0.stall = (id != 0) || st; i0.flush = (id == 0) && fl;
    i1.in_valid = (id == 1) && v; i1.stall = (id != 1) || st; i1.flush = (id == 1) && fl;
    i2.in_valid = (id == 2) && v; i2.stall = (id != 2) || st; i2.flush = (id == 2) && fl;
    for (int k = 0; k < 3; k++)
      model(k, d, sb, so, (id == k) && v, (id != k) || st, (id == k) && fl, r);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = q.pop_front();
      chk($sformatf("u%0d.dout", k), od[k], e.d);
      chk($sformatf("u%0d.out_valid", k), 32'(ov[k]), 32'(e.v));
      chk($sformatf("u%0d.sel_err", k), 32'(oe[k]), 32'(e.e));
      chk($sformatf("u%0d.err_cnt", k), 32'(oc[k]), 32'(e.c));
    end
  endtask
  initial begin
    logic [127:0] d;
    int id;
    step(0, {$urandom, $urandom, $urandom, $urandom}, 2'd1, 4'h3, 1, 0, 0, 1);
    step(0, {$urandom, $urandom, $urandom, $urandom}, 2'd3, 4'h5, 1, 1, 1, 1);
    chk("reset.dout", i0.dout, 32'h0);
    chk("reset.out_valid", 32'(i0.out_valid), 32'h0);
    chk("reset.err_cnt", 32'(i0.err_cnt), 32'h0);
    step(0, pack4(32'h1, 32'h2, 32'hDEADBEEF, 32'h4), 2'd2, 4'h0, 1, 0, 0, 0);
    chk("first.dout", i0.dout, 32'hDEADBEEF);
    chk("first.out_valid", 32'(i0.out_valid), 32'h1);
    d = pack4(32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003);
    for (int s = 0; s < 4; s++) begin
      step(0, d, 2'(s), 4'h0, 1, 0, 0, 0);
      chk("sweep.dout", i0.dout, 32'h10000000 + 32'(s));
      chk("sweep.sel_err", 32'(i0.sel_err), 32'h0);
    end
    step(0, pack4(32'h0, 32'hAAAA5555, 32'h0, 32'h0), 2'd1, 4'h0, 1, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      step(0, {$urandom, $urandom, $urandom, $urandom}, 2'($urandom), 4'h0, 1, 1, 0, 0);
      chk("stall.dout", i0.dout, 32'hAAAA5555);
      chk("stall.out_valid", 32'(i0.out_valid), 32'h1);
    end
    step(0, d, 2'd3, 4'h0, 1, 1, 1, 0);
    chk("flush_stall.dout", i0.dout, 32'h0);
    chk("flush_stall.out_valid", 32'(i0.out_valid), 32'h0);
    step(0, d, 2'd3, 4'h0, 1, 0, 0, 0);
    step(0, d, 2'd2, 4'h0, 1, 1, 0, 1);
    chk("rst_stall.dout", i0.dout, 32'h0);
    d = pack4(32'h11, 32'h22, 32'h33, 32'h44);
    step(1, d, 2'd2, 4'h0, 1, 0, 0, 0);
    step(1, d, 2'd3, 4'h0, 1, 0, 0, 0);
    chk("n3_ill.dout", i1.dout, 32'h0);
    chk("n3_ill.sel_err", 32'(i1.sel_err), 32'h1);
    chk("n3_ill.err_cnt", 32'(i1.err_cnt), 32'h1);
    step(1, d, 2'd3, 4'h0, 0, 0, 0, 0);
    chk("n3_inv.sel_err", 32'(i1.sel_err), 32'h0);
    chk("n3_inv.err_cnt", 32'(i1.err_cnt), 32'h1);
    d = pack4(32'h1, 32'h2, 32'h3, 32'h4);
    step(2, d, 2'd0, 4'b0100, 1, 0, 0, 0);
    chk("oh_one.dout", i2.dout, 32'h3);
    chk("oh_one.sel_err", 32'(i2.sel_err), 32'h0);
    step(2, d, 2'd0, 4'b0110, 1, 0, 0, 0);
    chk("oh_multi.dout", i2.dout, 32'h2);
    chk("oh_multi.sel_err", 32'(i2.sel_err), 32'h1);
    step(2, d, 2'd3, 4'b0000, 1, 0, 0, 0);
    chk("oh_zero.dout", i2.dout, 32'h0);
    chk("oh_zero.sel_err", 32'(i2.sel_err), 32'h1);
    chk("oh_zero.err_cnt", 32'(i2.err_cnt), 32'h2);
    step(2, d, 2'd3, 4'b1000, 1, 0, 0, 0);
    chk("oh_hi.dout", i2.dout, 32'h4);
    for (int s = 0; s < 300; s++) step(1, d, 2'd3, 4'h0, 1, 0, 0, 0);
    chk("sat.err_cnt", 32'(i1.err_cnt), 32'd255);
    step(1, d, 2'd3, 4'h0, 1, 0, 1, 0);
    chk("sat_flush.err_cnt", 32'(i1.err_cnt), 32'd255);
    step(1, d, 2'd3, 4'h0, 1, 0, 0, 1);
    chk("sat_rst.err_cnt", 32'(i1.err_cnt), 32'd0);
    for (int s = 0; s < 200; s++) begin
      id = int'($urandom_range(0, 2));
      step(id, {$urandom, $urandom, $urandom, $urandom}, 2'($urandom), 4'($urandom),
           1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
